// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus slot used by uart_tx_mmio: select, direction, byte address, lanes and data.
interface uart_tx_mmio_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output ce, we, addr, sel, data_i, input data_o);
  modport slave  (input ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, baud divisor and tx-done interrupt.
// Optional parity (8E1/8O1) is enabled by defining UART_TX_PARITY_EN.
module uart_tx_mmio #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_mmio_if.slave bus,
  output logic          tx,
  output logic          int_o
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state, state_n;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, busy, overflow, int_en;
  logic [15:0]   div, reload, baud_cnt, cnt_n;
  logic [7:0]    shift, shift_n;
  logic [2:0]    bit_idx, idx_n;
  logic          wr, wr_txdata, wr_status, wr_baud, wr_ctrl;
  logic          push_req, push, pop, bit_end, tx_n;
  logic [31:0]   count_ext;
  logic [3:0]    count_disp;
  logic [2:0]    ctrl_bits;
  logic          unused_bits;
`ifdef UART_TX_PARITY_EN
  logic          par_en, odd, par_bit, par_n;
`endif

  assign wr        = bus.ce & bus.we;
  assign wr_txdata = wr & (bus.addr[3:2] == 2'b00);
  assign wr_status = wr & (bus.addr[3:2] == 2'b01);
  assign wr_baud   = wr & (bus.addr[3:2] == 2'b10);
  assign wr_ctrl   = wr & (bus.addr[3:2] == 2'b11);

  // Full is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign push_req = wr_txdata & bus.sel[0];
  assign push     = push_req & ~full;
  assign reload   = (div == 16'd0) ? 16'd0 : div - 16'd1;
  assign bit_end  = (baud_cnt == 16'd0);

  assign count_ext   = 32'(count);
  assign count_disp  = (count_ext > 32'd15) ? 4'd15 : count_ext[3:0];
  assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.data_i[31:16], bus.sel[3:2]};

`ifdef UART_TX_PARITY_EN
  assign ctrl_bits = {odd, par_en, int_en};
`else
  assign ctrl_bits = {2'b00, int_en};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div      <= DEFAULT_DIV;
      int_en   <= 1'b0;
      overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en   <= 1'b0;
      odd      <= 1'b0;
`endif
    end else begin
      if (wr_baud & bus.sel[0]) div[7:0]  <= bus.data_i[7:0];
      if (wr_baud & bus.sel[1]) div[15:8] <= bus.data_i[15:8];
      if (wr_ctrl & bus.sel[0]) begin
        int_en <= bus.data_i[0];
`ifdef UART_TX_PARITY_EN
        par_en <= bus.data_i[1];
        odd    <= bus.data_i[2];
`endif
      end
      if (push_req & full)
        overflow <= 1'b1;
      else if (wr_status & bus.sel[0] & bus.data_i[3])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.data_i[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= 16'd0;
      shift    <= 8'd0;
      bit_idx  <= 3'd0;
      tx       <= 1'b1;
      int_o    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= cnt_n;
      shift    <= shift_n;
      bit_idx  <= idx_n;
      tx       <= tx_n;
      int_o    <= int_en & empty & ~busy;
`ifdef UART_TX_PARITY_EN
      par_bit  <= par_n;
`endif
    end
  end

  // The counter reloads from the live divisor on every bit boundary, so a divisor
  // change only affects the next bit; tx is registered from the next-state values.
  always_comb begin
    state_n = state;
    cnt_n   = bit_end ? 16'd0 : baud_cnt - 16'd1;
    shift_n = shift;
    idx_n   = bit_idx;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par_bit;
`endif
    case (state)
      IDLE: begin
        cnt_n = baud_cnt;
        if (!empty) begin
          pop     = 1'b1;
          state_n = START;
          cnt_n   = reload;
        end
      end
      START: if (bit_end) begin
        state_n = DATA;
        idx_n   = 3'd0;
        cnt_n   = reload;
      end
      DATA: if (bit_end) begin
        cnt_n = reload;
        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = par_en ? PARITY : STOP;
`else
          state_n = STOP;
`endif
        end else begin
          shift_n = {1'b0, shift[7:1]};
          idx_n   = bit_idx + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_n = STOP;
        cnt_n   = reload;
      end
`endif
      STOP: if (bit_end) begin
        cnt_n = reload;
        if (!empty) begin
          pop     = 1'b1;
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (pop) begin
      shift_n = fifo_mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
      par_n   = (^fifo_mem[rd_ptr]) ^ odd;
`endif
    end
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_comb begin
    bus.data_o = 32'h0;
    if (bus.ce && !bus.we) begin
      case (bus.addr[3:2])
        2'b01:   bus.data_o = {24'h0, count_disp, overflow, busy, empty, full};
        2'b10:   bus.data_o = {16'h0, div};
        2'b11:   bus.data_o = {29'h0, ctrl_bits};
        default: bus.data_o = 32'h0;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: register vector table plus directed frame sequences.
module tb_uart_tx_mmio;
  logic clk = 1'b0;
  logic rst;
  logic tx, int_o;
  logic [31:0] rd;
  int checks = 0;
  int errors = 0;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx), .int_o(int_o)
  );

  always #5 clk = ~clk;

`ifdef UART_TX_PARITY_EN
  localparam logic [31:0] CTRL_ALL = 32'h7;
`else
  localparam logic [31:0] CTRL_ALL = 32'h1;
`endif

  typedef struct {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_int;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    bus.ce = v.ce; bus.we = v.we; bus.addr = v.addr; bus.sel = v.sel; bus.data_i = v.data;
    #1;
    checkOutput($sformatf("vec%0d data_o", idx), bus.data_o, v.exp_data);
    @(negedge clk);
    bus.ce = 1'b0; bus.we = 1'b0;
    checkOutput($sformatf("vec%0d int_o", idx), {31'h0, int_o}, {31'h0, v.exp_int});
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    @(negedge clk);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = a; bus.sel = s; bus.data_i = d;
    @(negedge clk);
    bus.ce = 1'b0; bus.we = 1'b0;
  endtask

  task automatic read_now(input logic [31:0] a, output logic [31:0] d);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1;
    d = bus.data_o;
    bus.ce = 1'b0;
  endtask

  function automatic logic line_bit(input logic [7:0] b, input int k, input int dv);
    int bi;
    bi = k / dv;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
    return 1'b1;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b3 [3];
    logic [31:0] exp;
    int bad;

    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.sel = 4'h0; bus.data_i = 32'h0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset tx", {31'h0, tx}, 32'h1);
    checkOutput("reset int_o", {31'h0, int_o}, 32'h0);
    rst = 1'b1;

    // ce, we, addr, sel, data, expected data_o, expected int_o
    vecs.push_back('{1'b1, 1'b0, 32'h0, 4'hF, 32'h0,        32'h0,    1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h4, 4'hF, 32'h0,        32'h2,    1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h8, 4'hF, 32'h0,        32'h1B2,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'hC, 4'hF, 32'h0,        32'h0,    1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h4, 4'hF, 32'h0,        32'h0,    1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h8, 4'h1, 32'h12345678, 32'h0,    1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h8, 4'hF, 32'h0,        32'h178,  1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h8, 4'h2, 32'h0000AB00, 32'h0,    1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h8, 4'hF, 32'h0,        32'hAB78, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h8, 4'hC, 32'hFFFFFFFF, 32'h0,    1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h8, 4'hF, 32'h0,        32'hAB78, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h0, 4'h2, 32'h000000FF, 32'h0,    1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h4, 4'hF, 32'h0,        32'h2,    1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h4, 4'h1, 32'hFFFFFFF7, 32'h0,    1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h4, 4'hF, 32'h0,        32'h2,    1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'hC, 4'h1, 32'hFFFFFFFF, 32'h0,    1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'hC, 4'hF, 32'h0,        CTRL_ALL, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'hC, 4'hE, 32'h0,        32'h0,    1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'hC, 4'hF, 32'h0,        CTRL_ALL, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'hC, 4'h1, 32'h0,        32'h0,    1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'hC, 4'hF, 32'h0,        32'h0,    1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h4, 4'hF, 32'h0,        32'h2,    1'b0});
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Single 0xA5 frame at 4 clocks per bit.
    bus_write(32'h8, 4'h3, 32'h4);
    @(negedge clk);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = 32'h0; bus.sel = 4'h1; bus.data_i = 32'hA5;
    @(negedge clk);
    bus.ce = 1'b0; bus.we = 1'b0;
    checkOutput("t2 tx before start", {31'h0, tx}, 32'h1);
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      exp = (k < 40) ? {31'h0, line_bit(8'hA5, k, 4)} : 32'h1;
      checkOutput($sformatf("t2 tx k%0d", k), {31'h0, tx}, exp);
      if (k == 20) begin read_now(32'h4, rd); checkOutput("t2 busy mid", {31'h0, rd[2]}, 32'h1); end
      if (k == 40) begin read_now(32'h4, rd); checkOutput("t2 status after", rd, 32'h2); end
    end

    // Three back-to-back frames at 2 clocks per bit.
    bus_write(32'h8, 4'h3, 32'h2);
    b3[0] = 8'h3C; b3[1] = 8'hC3; b3[2] = 8'h81;
    @(negedge clk);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = 32'h0; bus.sel = 4'h1; bus.data_i = {24'h0, b3[0]};
    @(negedge clk);
    checkOutput("t3 tx idle", {31'h0, tx}, 32'h1);
    bus.data_i = {24'h0, b3[1]};
    @(negedge clk);
    checkOutput("t3 tx k0", {31'h0, tx}, 32'h0);
    bus.data_i = {24'h0, b3[2]};
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.ce = 1'b0; bus.we = 1'b0; end
      if (k < 60) exp = {31'h0, line_bit(b3[k/20], k % 20, 2)};
      else        exp = 32'h1;
      checkOutput($sformatf("t3 tx k%0d", k), {31'h0, tx}, exp);
      if (k == 1 || k == 19) begin read_now(32'h4, rd); checkOutput($sformatf("t3 count k%0d", k), {28'h0, rd[7:4]}, 32'h2); end
      if (k == 20) begin read_now(32'h4, rd); checkOutput("t3 count k20", {28'h0, rd[7:4]}, 32'h1); end
      if (k == 40) begin read_now(32'h4, rd); checkOutput("t3 count k40", {28'h0, rd[7:4]}, 32'h0); end
      if (k == 60) begin read_now(32'h4, rd); checkOutput("t3 status after", rd, 32'h2); end
    end

    // Overflow: one byte in flight, then nine pushes into an 8-deep FIFO.
    bus_write(32'h8, 4'h3, 32'd100);
    bus_write(32'h0, 4'h1, 32'h11);
    for (int i = 0; i < 9; i++) bus_write(32'h0, 4'h1, 32'h20 + i);
    read_now(32'h4, rd);
    checkOutput("t4 status full+overflow", rd, 32'h8D);
    bus_write(32'h4, 4'h1, 32'h08);
    read_now(32'h4, rd);
    checkOutput("t4 overflow cleared", rd, 32'h85);

    @(negedge clk); #2; rst = 1'b0; #1;
    checkOutput("t4 reset tx", {31'h0, tx}, 32'h1);
    read_now(32'h4, rd);
    checkOutput("t4 reset status", rd, 32'h2);
    @(negedge clk); rst = 1'b1;

    // Reset in the middle of the data bits with two bytes still queued.
    bus_write(32'h8, 4'h3, 32'h4);
    bus_write(32'h0, 4'h1, 32'h00);
    bus_write(32'h0, 4'h1, 32'hFF);
    bus_write(32'h0, 4'h1, 32'hFF);
    repeat (6) @(negedge clk);
    checkOutput("t6 tx in data", {31'h0, tx}, 32'h0);
    read_now(32'h4, rd);
    checkOutput("t6 status before reset", rd, 32'h24);
    #2; rst = 1'b0; #1;
    checkOutput("t6 tx in reset", {31'h0, tx}, 32'h1);
    checkOutput("t6 int in reset", {31'h0, int_o}, 32'h0);
    read_now(32'h4, rd);
    checkOutput("t6 status in reset", rd, 32'h2);
    read_now(32'h8, rd);
    checkOutput("t6 bauddiv in reset", rd, 32'h1B2);
    @(negedge clk); rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    checkOutput("t6 line quiet after reset", bad, 32'h0);
    read_now(32'h4, rd);
    checkOutput("t6 status after release", rd, 32'h2);

    // Interrupt around a frame with a stored divisor of 0 (one clock per bit).
    bus_write(32'h8, 4'h3, 32'h0);
    bus_write(32'hC, 4'h1, 32'h1);
    @(negedge clk);
    checkOutput("t5 int idle", {31'h0, int_o}, 32'h1);
    @(negedge clk);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = 32'h0; bus.sel = 4'h1; bus.data_i = 32'h55;
    @(negedge clk);
    bus.ce = 1'b0; bus.we = 1'b0;
    checkOutput("t5 int at push", {31'h0, int_o}, 32'h1);
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      exp = (k < 10) ? {31'h0, line_bit(8'h55, k, 1)} : 32'h1;
      checkOutput($sformatf("t5 tx k%0d", k), {31'h0, tx}, exp);
      checkOutput($sformatf("t5 int k%0d", k), {31'h0, int_o}, (k >= 11) ? 32'h1 : 32'h0);
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of 0x07 is 1; frame gains one bit between data and stop.
    bus_write(32'hC, 4'h1, 32'h3);
    @(negedge clk);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = 32'h0; bus.sel = 4'h1; bus.data_i = 32'h07;
    @(negedge clk);
    bus.ce = 1'b0; bus.we = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      if (k == 0)      exp = 32'h0;
      else if (k <= 8) exp = {31'h0, line_bit(8'h07, k, 1)};
      else             exp = 32'h1;
      checkOutput($sformatf("par tx k%0d", k), {31'h0, tx}, exp);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
